// File: rtl/dual_port_ram_pkg.sv
// Default geometry and word type for the 16x8 simple dual-port RAM.
package dual_port_ram_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DEPTH  = 16;

  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage : dual_port_ram_pkg

// File: rtl/dual_port_ram_16x8.sv
// Simple dual-port RAM: write-only port A, read-only port B, single clock.
// Read data is registered (one-cycle latency); a same-address write/read
// on one edge returns the newly written data (write-through).
module dual_port_ram_16x8
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  output logic              valid_b
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // True when an address maps onto an implemented word.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < 32'(DEPTH);
  endfunction

  // Array index for an in-range address.
  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr);
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_b;
  logic              r_valid_b;

  logic              w_wr_en;
  logic              w_rd_in_range;
  logic              w_collide;
  logic [DATA_W-1:0] w_rd_data;

  assign w_wr_en       = we_a && in_range(addr_a);
  assign w_rd_in_range = in_range(addr_b);
  assign w_collide     = w_wr_en && (addr_a == addr_b);

  // Read mux: out-of-range reads return zero, collisions forward write data.
  always_comb begin
    w_rd_data = '0;
    if (w_rd_in_range) begin
      w_rd_data = w_collide ? data_a : r_mem[idx(addr_b)];
    end
  end

  // Storage and read register; reset clears every word and the read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_data_b  <= '0;
      r_valid_b <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[idx(addr_a)] <= data_a;
      end
      if (re_b) begin
        r_data_b <= w_rd_data;
      end
      r_valid_b <= re_b;
    end
  end

  assign data_b  = r_data_b;
  assign valid_b = r_valid_b;

endmodule : dual_port_ram_16x8

// File: tb/tb_dual_port_ram_16x8.sv
// Directed, table-driven bench for dual_port_ram_16x8 (default 16-deep
// instance plus a 12-deep instance for out-of-range behaviour).
module tb_dual_port_ram_16x8;
  import dual_port_ram_pkg::*;

  typedef struct {
    logic       rst_n;
    logic       we_a;
    logic [3:0] addr_a;
    logic [7:0] data_a;
    logic       re_b;
    logic [3:0] addr_b;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;

  localparam int NVEC = 18;

  logic       clk;
  logic       rst_n;
  logic       we_a;
  logic [3:0] addr_a;
  word_t      data_a;
  logic       re_b;
  logic [3:0] addr_b;
  word_t      data_b;
  logic       valid_b;
  word_t      data_b12;
  logic       valid_b12;

  int n_pass  = 0;
  int n_total = 0;

  vec_t vecs [NVEC];

  dual_port_ram_16x8 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_a   (we_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .re_b   (re_b),
    .addr_b (addr_b),
    .data_b (data_b),
    .valid_b(valid_b)
  );

  dual_port_ram_16x8 #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) dut12 (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_a   (we_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .re_b   (re_b),
    .addr_b (addr_b),
    .data_b (data_b12),
    .valid_b(valid_b12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic we, input logic [3:0] aa,
                              input logic [7:0] da, input logic re, input logic [3:0] ab,
                              input logic [7:0] ed, input logic ev);
    vec_t v;
    v.rst_n = r;  v.we_a = we; v.addr_a = aa; v.data_a = da;
    v.re_b = re;  v.addr_b = ab; v.exp_data = ed; v.exp_valid = ev;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs at the falling edge, then sample after the rising edge.
  task automatic step(input logic r, input logic we, input logic [3:0] aa,
                      input logic [7:0] da, input logic re, input logic [3:0] ab);
    @(negedge clk);
    rst_n = r; we_a = we; addr_a = aa; data_a = da; re_b = re; addr_b = ab;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; we_a = 1'b0; addr_a = '0; data_a = '0; re_b = 1'b0; addr_b = '0;

    //               rst we  aa    da     re  ab    exp    v
    vecs[0]  = mk(1'b0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0); // reset edge 1
    vecs[1]  = mk(1'b0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0); // reset edge 2
    vecs[2]  = mk(1'b1, 0, 4'd0, 8'h00, 1, 4'd3, 8'h00, 1); // read after reset
    vecs[3]  = mk(1'b1, 1, 4'd3, 8'hAA, 0, 4'd0, 8'h00, 0); // write AA@3
    vecs[4]  = mk(1'b1, 1, 4'd5, 8'h55, 0, 4'd0, 8'h00, 0); // write 55@5
    vecs[5]  = mk(1'b1, 0, 4'd0, 8'h00, 1, 4'd3, 8'hAA, 1); // read 3
    vecs[6]  = mk(1'b1, 0, 4'd0, 8'h00, 1, 4'd5, 8'h55, 1); // read 5 back-to-back
    vecs[7]  = mk(1'b1, 0, 4'd0, 8'h00, 0, 4'd3, 8'h55, 0); // hold
    vecs[8]  = mk(1'b1, 1, 4'd7, 8'h3C, 1, 4'd7, 8'h3C, 1); // collision
    vecs[9]  = mk(1'b1, 0, 4'd0, 8'h00, 1, 4'd7, 8'h3C, 1); // later read of 7
    vecs[10] = mk(1'b1, 1, 4'd2, 8'h11, 0, 4'd0, 8'h3C, 0); // write 11@2
    vecs[11] = mk(1'b0, 1, 4'd4, 8'h99, 1, 4'd2, 8'h00, 0); // reset ignores we/re
    vecs[12] = mk(1'b1, 0, 4'd0, 8'h00, 1, 4'd2, 8'h00, 1); // read 2 cleared
    vecs[13] = mk(1'b1, 0, 4'd0, 8'h00, 1, 4'd4, 8'h00, 1); // read 4 not written
    vecs[14] = mk(1'b1, 1, 4'd9, 8'h5A, 0, 4'd0, 8'h00, 0); // write 5A@9
    vecs[15] = mk(1'b1, 0, 4'd0, 8'h00, 1, 4'd9, 8'h5A, 1); // read next edge
    vecs[16] = mk(1'b1, 1, 4'd15, 8'hC3, 0, 4'd0, 8'h5A, 0); // write top word
    vecs[17] = mk(1'b1, 0, 4'd0, 8'h00, 1, 4'd15, 8'hC3, 1); // read top word

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst_n, vecs[i].we_a, vecs[i].addr_a, vecs[i].data_a,
           vecs[i].re_b, vecs[i].addr_b);
      check($sformatf("v%0d_data", i), data_b, vecs[i].exp_data);
      check($sformatf("v%0d_valid", i), 8'(valid_b), 8'(vecs[i].exp_valid));
    end

    // Out-of-range handling on the 12-deep instance.
    step(1'b1, 1'b1, 4'd1, 8'h21, 1'b1, 4'd15);   // write 21@1; read 15 (dropped on dut12)
    check("d12_rd15_data", data_b12, 8'h00);
    check("d12_rd15_valid", 8'(valid_b12), 8'h01);
    check("d16_rd15_data", data_b, 8'hC3);
    step(1'b1, 1'b1, 4'd13, 8'hFF, 1'b0, 4'd0);  // write FF@13
    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd13);  // read 13
    check("d12_rd13_data", data_b12, 8'h00);
    check("d12_rd13_valid", 8'(valid_b12), 8'h01);
    check("d16_rd13_data", data_b, 8'hFF);
    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd1);   // word 1 must be untouched
    check("d12_rd1_data", data_b12, 8'h21);
    check("d12_rd1_valid", 8'(valid_b12), 8'h01);
    step(1'b1, 1'b1, 4'd12, 8'h77, 1'b1, 4'd12); // out-of-range collision: no forward
    check("d12_coll12_data", data_b12, 8'h00);
    check("d16_coll12_data", data_b, 8'h77);
    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd0);   // word 0 (12 mod 12) untouched
    check("d12_rd0_data", data_b12, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dual_port_ram_16x8

// File: doc/dual_port_ram_16x8.md
Name: dual_port_ram_16x8

Overview:
Simple dual-port synchronous RAM with one write-only port (A) and one read-only port (B), both on a single clock. Default geometry is 16 words × 8 bits. It is used as a small scratch/buffer memory between a producer that writes and a consumer that reads independently. Read data is registered, with one-cycle latency.

Parameters:
DATA_W, 8, width of each stored word and of data_a/data_b
ADDR_W, 4, width of addr_a/addr_b
DEPTH, 16, number of words implemented; must satisfy 1 <= DEPTH <= 2**ADDR_W

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  reset, synchronous, active-low
we_a  input  1  port A write enable
addr_a  input  ADDR_W  port A write address
data_a  input  DATA_W  port A write data
re_b  input  1  port B read enable
addr_b  input  ADDR_W  port B read address
data_b  output  DATA_W  port B registered read data
valid_b  output  1  high for one cycle when data_b was loaded by a read in the previous cycle

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. It is sampled only on the rising edge of clk.
- Reset (rst_n=0 at a rising edge):
  - all DEPTH words cleared to 0
  - data_b <= 0, valid_b <= 0
  - any we_a/re_b in the same cycle is ignored
- Write: on a rising edge with rst_n=1, we_a=1 and addr_a<DEPTH, mem[addr_a] <= data_a.
- Write out of range: with addr_a>=DEPTH, the write is silently dropped.
- Read:
  - on a rising edge with rst_n=1 and re_b=1, data_b <= mem[addr_b] and valid_b <= 1
  - data is visible after that edge (1-cycle latency from sampled re_b/addr_b)
  - addr_b>=DEPTH returns 0, and valid_b is still 1
- No read: with re_b=0, data_b holds its last value and valid_b <= 0.
- Collision (we_a=1, re_b=1, addr_a==addr_b, in range, same edge): write-through. data_b <= data_a (the new data) and mem is updated.
- Different-address simultaneous write/read: fully independent, no stalls.
- Consecutive reads on back-to-back cycles are supported at full rate; each produces data one edge later.
- Write of a location immediately followed by a read of it on the next edge returns the new value.
- No X on outputs after the first reset.
- The memory array has no other reset source.

Decomposition:
- Package dual_port_ram_pkg: default DATA_W/ADDR_W/DEPTH localparams and a word typedef (logic [DATA_W-1:0]).
- Single module. The storage array and the read register stay in the top. No sub-module is required.
- An optional internal helper function in_range(addr) is shared by both ports.

Test Plan:
1. Reset then read: hold rst_n=0 for 2 edges, release, read addr 3 with re_b=1 -> data_b=0x00, valid_b=1 one edge later.
2. Basic write/read:
   - write 0xAA@3, then 0x55@5 on consecutive edges, then we_a=0
   - read addr 3, then addr 5 on consecutive edges
   - expect data_b=0xAA then 0x55, each one edge after its read is sampled, valid_b=1 both cycles
3. Hold: after test 2, set re_b=0 and change addr_b to 3 -> data_b stays 0x55, valid_b=0.
4. Collision: we_a=1, addr_a=7, data_a=0x3C and re_b=1, addr_b=7 on the same edge -> data_b=0x3C next cycle. A later read of 7 also returns 0x3C.
5. Reset mid-operation:
   - write 0x11@2, then assert rst_n=0 for one edge with we_a=1, addr_a=4, data_a=0x99
   - after release, read 2 -> 0x00, read 4 -> 0x00, data_b=0 during reset
6. Out-of-range with DEPTH=12:
   - write 0xFF@13 -> dropped
   - read 13 -> data_b=0x00, valid_b=1
   - word 1 (13 mod 12) is unchanged
